operand_unpacker: RTL and testbench
===================================

OPERAND_UNPACKER -- requirements
Module: operand_unpacker

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-003 The module SHALL have the port in_valid, input, 1 bit, asserted when an operand pair is presented.
REQ-004 The module SHALL have the port in_ready, output, 1 bit, asserted when the module accepts an operand pair this cycle.
REQ-005 The module SHALL have the port operand_a, input, 32 bits, an IEEE-754 single-precision operand.
REQ-006 The module SHALL have the port operand_b, input, 32 bits, an IEEE-754 single-precision operand.
REQ-007 The module SHALL have the port out_valid, output, 1 bit, asserted when unpacked results are held.
REQ-008 The module SHALL have the port out_ready, input, 1 bit, asserted when downstream consumes the results.
REQ-009 The module SHALL have the ports sign_a and sign_b, outputs, 1 bit each, the operand sign bits.
REQ-010 The module SHALL have the ports raw_exponent_a and raw_exponent_b, outputs, 8 bits each, the unmodified [30:23] fields.
REQ-011 The module SHALL have the ports exponent_a and exponent_b, outputs, 10 bits each, the biased exponent as a two's-complement value.
REQ-012 The module SHALL have the ports fraction_a and fraction_b, outputs, 32 bits each, the significand in [xx.xxxx...] format (2 integer bits, 30 fractional bits).
REQ-013 The module SHALL have the ports class_a and class_b, outputs, 5 bits each, a one-hot classification {snan, qnan, inf, subnormal, zero} in bits [4:0].

Function
REQ-014 Transfer occurs on in_valid & in_ready (input side) and on out_valid & out_ready (output side).
REQ-015 The module SHALL have two register stages: S1 holds the captured operands plus classification and leading-zero count; S2 holds the final unpacked fields.
REQ-016 Latency from input transfer to out_valid SHALL be exactly 2 cycles when there is no backpressure; throughput SHALL be one pair per cycle.
REQ-017 Stall rules: S2 loads when S2 is empty or out_ready=1; S1 loads when S1 is empty or S2 loads; in_ready = S1 empty or S2 loads (combinational, no bubble).
REQ-018 While out_valid=1 and out_ready=0, every output SHALL hold stable.
REQ-019 Normal operand (exp 1..254): exponent = {2'b00, exp}; fraction = {2'b01, frac[22:0], 7'b0}.
REQ-020 Zero (exp 0, frac 0): class zero; exponent = 0; fraction = 0.
REQ-021 Inf (exp 255, frac 0): class inf; exponent = 255; fraction = {2'b01, 30'b0}.
REQ-022 NaN (exp 255, frac≠0): class qnan if frac[22]=1, otherwise snan; exponent = 255; fraction = {2'b01, frac, 7'b0}.
REQ-023 Subnormal (exp 0, frac≠0): class subnormal; handling is set by REQ-028/REQ-029.
REQ-024 The sign and raw_exponent outputs SHALL always pass through unchanged for every class.

Reset
REQ-025 While reset_n=0, S1/S2 valid flags SHALL clear immediately and all datapath outputs SHALL read 0; consequently out_valid=0 and in_ready=1 once S1 is empty.
REQ-026 Reset asserted mid-stream SHALL discard in-flight pairs without emitting them.
REQ-027 The first transfer after reset deassertion SHALL be accepted on the first rising edge at which reset_n=1.

Configuration
REQ-028 With UNPACKER_SUBNORMAL_NORMALIZE_EN defined, for a subnormal operand with z = leading zeros of frac[22:0] (0..22): fraction = {2'b00, frac, 7'b0} << (z+1), so that bit 30 = 1; exponent = -z as a 10-bit two's-complement value.
REQ-029 Without UNPACKER_SUBNORMAL_NORMALIZE_EN, subnormal operands SHALL be flushed: fraction = 0; exponent = 0; class = subnormal|zero (both bits set); no leading-zero logic is instantiated.

Verification
REQ-030 Test: a=0x3F800000, b=0xC0000000, out_ready=1 -> after 2 cycles exponent_a=127, fraction_a=0x40000000, sign_b=1, exponent_b=128.
REQ-031 Test: a=0x7F800000, b=0x7FC00001 -> class_a=inf (5'b00100), class_b=qnan; a=0x7F800001 -> class=snan.
REQ-032 Test (EN defined): a=0x00000001 -> z=22, exponent_a=10'h3EA (-22), fraction_a=0x40000000; a=0x00400000 -> exponent_a=0, fraction_a=0x40000000.
REQ-033 Test (EN undefined): a=0x00400000 -> fraction_a=0, exponent_a=0, class_a=5'b00011.
REQ-034 Test: stream 4 pairs with out_ready=0 for 3 cycles -> in_ready drops after 2 pairs are accepted; outputs stay stable; all 4 pairs emerge in order without loss or duplication.
REQ-035 Test: assert reset_n=0 with 2 pairs in flight -> out_valid=0 immediately; no stale pair appears after release.

Source files
------------

// File: rtl/operand_unpacker.sv
// Two-stage IEEE-754 single-precision operand unpacker with valid/ready flow control.
// Define UNPACKER_SUBNORMAL_NORMALIZE_EN to normalize subnormals; otherwise they flush to zero.

module operand_unpack_lane (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s1_cap,
    input  logic        s2_cap,
    input  logic [31:0] operand,
    output logic        sign,
    output logic [7:0]  raw_exponent,
    output logic [9:0]  exponent,
    output logic [31:0] fraction,
    output logic [4:0]  cls
);
    logic [7:0]  exp_f;
    logic [22:0] frac_f;
    logic        is_max, is_min, frac_nz;
    logic [4:0]  cls_c;
    logic [31:0] s1_op;
    logic [4:0]  s1_cls;
    logic [7:0]  s1_exp;
    logic [22:0] s1_frac;
    logic [9:0]  exp_c;
    logic [31:0] frac_c;

    assign exp_f   = operand[30:23];
    assign frac_f  = operand[22:0];
    assign is_max  = &exp_f;
    assign is_min  = ~|exp_f;
    assign frac_nz = |frac_f;

    // One-hot {snan, qnan, inf, subnormal, zero}; flushed subnormals also carry the zero bit
`ifdef UNPACKER_SUBNORMAL_NORMALIZE_EN
    assign cls_c = {is_max & frac_nz & ~frac_f[22], is_max & frac_f[22], is_max & ~frac_nz,
                    is_min & frac_nz, is_min & ~frac_nz};
`else
    assign cls_c = {is_max & frac_nz & ~frac_f[22], is_max & frac_f[22], is_max & ~frac_nz,
                    is_min & frac_nz, is_min};
`endif

`ifdef UNPACKER_SUBNORMAL_NORMALIZE_EN
    logic [4:0] lz_c, s1_lz;
    logic       found;

    always_comb begin
        lz_c  = '0;
        found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!found && frac_f[i]) begin
                lz_c  = 5'(22 - i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) s1_lz <= '0;
        else if (s1_cap) s1_lz <= lz_c;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_op  <= '0;
            s1_cls <= '0;
        end else if (s1_cap) begin
            s1_op  <= operand;
            s1_cls <= cls_c;
        end
    end

    assign s1_exp  = s1_op[30:23];
    assign s1_frac = s1_op[22:0];

    // Normal, inf and NaN share the implicit-one layout; exp==0 covers zero and subnormal
    always_comb begin
        exp_c  = {2'b00, s1_exp};
        frac_c = {2'b01, s1_frac, 7'b0};
        if (s1_exp == 8'd0) begin
            exp_c  = '0;
            frac_c = '0;
`ifdef UNPACKER_SUBNORMAL_NORMALIZE_EN
            if (s1_cls[1]) begin
                frac_c = {2'b00, s1_frac, 7'b0} << (s1_lz + 5'd1);
                exp_c  = -{5'b0, s1_lz};
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign         <= 1'b0;
            raw_exponent <= '0;
            exponent     <= '0;
            fraction     <= '0;
            cls          <= '0;
        end else if (s2_cap) begin
            sign         <= s1_op[31];
            raw_exponent <= s1_exp;
            exponent     <= exp_c;
            fraction     <= frac_c;
            cls          <= s1_cls;
        end
    end
endmodule

module operand_unpacker (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_a,
    output logic        sign_b,
    output logic [7:0]  raw_exponent_a,
    output logic [7:0]  raw_exponent_b,
    output logic [9:0]  exponent_a,
    output logic [9:0]  exponent_b,
    output logic [31:0] fraction_a,
    output logic [31:0] fraction_b,
    output logic [4:0]  class_a,
    output logic [4:0]  class_b
);
    localparam int STAGES    = 2;
    localparam int NUM_LANES = 2;

    logic [STAGES:1]                  vld_pipe;
    logic                             s1_ld, s2_ld, s1_cap, s2_cap;
    logic [NUM_LANES-1:0][31:0]       opnd;
    logic [NUM_LANES-1:0]             sgn;
    logic [NUM_LANES-1:0][7:0]        rexp;
    logic [NUM_LANES-1:0][9:0]        uexp;
    logic [NUM_LANES-1:0][31:0]       ufrac;
    logic [NUM_LANES-1:0][4:0]        ucls;

    // Each stage advances when it is empty or the stage after it is advancing
    assign s2_ld     = !vld_pipe[2] || out_ready;
    assign s1_ld     = !vld_pipe[1] || s2_ld;
    assign in_ready  = s1_ld;
    assign out_valid = vld_pipe[2];
    assign s1_cap    = s1_ld && in_valid;
    assign s2_cap    = s2_ld && vld_pipe[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            if (s1_ld) vld_pipe[1] <= in_valid;
            if (s2_ld) vld_pipe[2] <= vld_pipe[1];
        end
    end

    assign opnd = {operand_b, operand_a};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        operand_unpack_lane u_lane (
            .clk          (clk),
            .reset_n      (reset_n),
            .s1_cap       (s1_cap),
            .s2_cap       (s2_cap),
            .operand      (opnd[i]),
            .sign         (sgn[i]),
            .raw_exponent (rexp[i]),
            .exponent     (uexp[i]),
            .fraction     (ufrac[i]),
            .cls          (ucls[i])
        );
    end

    assign sign_a         = sgn[0];
    assign sign_b         = sgn[1];
    assign raw_exponent_a = rexp[0];
    assign raw_exponent_b = rexp[1];
    assign exponent_a     = uexp[0];
    assign exponent_b     = uexp[1];
    assign fraction_a     = ufrac[0];
    assign fraction_b     = ufrac[1];
    assign class_a        = ucls[0];
    assign class_b        = ucls[1];
endmodule

// File: tb/tb_operand_unpacker.sv
// Randomized and directed bench for operand_unpacker against a behavioural IEEE-754 unpack model.
// Honors UNPACKER_SUBNORMAL_NORMALIZE_EN the same way the design does.

module tb_operand_unpacker;
    typedef struct packed {
        logic        sign;
        logic [7:0]  rexp;
        logic [9:0]  exp;
        logic [31:0] frac;
        logic [4:0]  cls;
    } lane_t;

    typedef struct packed {
        lane_t a;
        lane_t b;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_a, sign_b;
    logic [7:0]  raw_exponent_a, raw_exponent_b;
    logic [9:0]  exponent_a, exponent_b;
    logic [31:0] fraction_a, fraction_b;
    logic [4:0]  class_a, class_b;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    obs_t        got_q[$];

    operand_unpacker dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(a), .operand_b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sign_a(sign_a), .sign_b(sign_b),
        .raw_exponent_a(raw_exponent_a), .raw_exponent_b(raw_exponent_b),
        .exponent_a(exponent_a), .exponent_b(exponent_b),
        .fraction_a(fraction_a), .fraction_b(fraction_b),
        .class_a(class_a), .class_b(class_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic lane_t ref_unpack(input logic [31:0] x);
        lane_t l;
        int e, f, p;
        e = x[30:23];
        f = x[22:0];
        l.sign = x[31];
        l.rexp = x[30:23];
        l.exp  = '0;
        l.frac = '0;
        l.cls  = '0;
        if (e == 255) begin
            l.exp  = 10'd255;
            l.frac = 32'h4000_0000 + (32'(f) << 7);
            if (f == 0) l.cls = 5'b00100;
            else if (f >= 32'h40_0000) l.cls = 5'b01000;
            else l.cls = 5'b10000;
        end else if (e == 0 && f == 0) begin
            l.cls = 5'b00001;
        end else if (e == 0) begin
`ifdef UNPACKER_SUBNORMAL_NORMALIZE_EN
            p = 0;
            for (int i = 0; i < 23; i++) if (f >= (1 << i)) p = i;
            l.cls  = 5'b00010;
            l.frac = 32'(f) << (30 - p);
            l.exp  = 10'(p - 22);
`else
            p = 0;
            l.cls = 5'b00011;
`endif
        end else begin
            l.exp  = 10'(e);
            l.frac = 32'h4000_0000 + (32'(f) << 7);
        end
        return l;
    endfunction

    function automatic obs_t model(input logic [63:0] pair);
        obs_t o;
        o.a = ref_unpack(pair[63:32]);
        o.b = ref_unpack(pair[31:0]);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.a = {sign_a, raw_exponent_a, exponent_a, fraction_a, class_a};
        o.b = {sign_b, raw_exponent_b, exponent_b, fraction_b, class_b};
        return o;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic [22:0] f;
        logic [7:0]  e;
        r = $urandom;
        f = r[22:0];
        case ($urandom_range(0, 5))
            0: return {r[31], 8'd0, 23'd0};
            1: begin
                f = f >> $urandom_range(0, 22);
                if (f == 0) f = 23'd1;
                return {r[31], 8'd0, f};
            end
            2: return {r[31], 8'hff, 23'd0};
            3: return {r[31], 8'hff, f | 23'd1};
            default: begin
                e = 8'($urandom_range(1, 254));
                return {r[31], e, f};
            end
        endcase
    endfunction

    // Records transfers seen just before the coming rising edge, then steps past it
    task automatic tick();
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back({a, b});
        if (out_valid && out_ready) got_q.push_back(sample());
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] xa, input logic [31:0] xb,
                            output obs_t o, output logic v1, output logic v2);
        in_valid = 1'b1; a = xa; b = xb; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        v1 = out_valid;
        tick();
        v2 = out_valid;
        o = sample();
        tick();
    endtask

    task automatic test_reset();
        obs_t o;
        exp_q.delete(); got_q.delete();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        o = sample();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want 0", o);
        end
        // First edge after release must already accept
        reset_n = 1'b1; in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h4040_0000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 1) begin
            failures++;
            $display("FAIL reset_first_accept accepted=%0d want 1", exp_q.size());
        end
        repeat (3) tick();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== model({32'h3F80_0000, 32'h4040_0000})) begin
            failures++;
            $display("FAIL reset_first_result count=%0d", got_q.size());
        end
    endtask

    task automatic test_directed();
        obs_t o;
        logic v1, v2;
        exp_q.delete(); got_q.delete();
        send_one(32'h3F80_0000, 32'hC000_0000, o, v1, v2);
        checks++;
        if (v1 !== 1'b0 || v2 !== 1'b1) begin
            failures++;
            $display("FAIL latency out_valid cyc1=%b cyc2=%b want 0/1", v1, v2);
        end
        checks++;
        if (o.a.exp !== 10'd127 || o.a.frac !== 32'h4000_0000 || o.b.sign !== 1'b1 || o.b.exp !== 10'd128) begin
            failures++;
            $display("FAIL normal_fields exp_a=%h frac_a=%h sign_b=%b exp_b=%h want 07f/40000000/1/080",
                     o.a.exp, o.a.frac, o.b.sign, o.b.exp);
        end
        checks++;
        if (o !== model({32'h3F80_0000, 32'hC000_0000})) begin
            failures++;
            $display("FAIL normal_model got=%h want=%h", o, model({32'h3F80_0000, 32'hC000_0000}));
        end
        send_one(32'h7F80_0000, 32'h7FC0_0001, o, v1, v2);
        checks++;
        if (o.a.cls !== 5'b00100 || o.b.cls !== 5'b01000 || o.a.exp !== 10'd255 || o.a.frac !== 32'h4000_0000) begin
            failures++;
            $display("FAIL inf_qnan cls_a=%b cls_b=%b exp_a=%h frac_a=%h want 00100/01000/0ff/40000000",
                     o.a.cls, o.b.cls, o.a.exp, o.a.frac);
        end
        send_one(32'h7F80_0001, 32'h8000_0000, o, v1, v2);
        checks++;
        if (o.a.cls !== 5'b10000 || o.b.cls !== 5'b00001 || o.b.sign !== 1'b1 || o.b.frac !== 32'h0) begin
            failures++;
            $display("FAIL snan_negzero cls_a=%b cls_b=%b sign_b=%b frac_b=%h want 10000/00001/1/0",
                     o.a.cls, o.b.cls, o.b.sign, o.b.frac);
        end
`ifdef UNPACKER_SUBNORMAL_NORMALIZE_EN
        send_one(32'h0000_0001, 32'h0040_0000, o, v1, v2);
        checks++;
        if (o.a.exp !== 10'h3EA || o.a.frac !== 32'h4000_0000 || o.b.exp !== 10'h000
            || o.b.frac !== 32'h4000_0000 || o.a.cls !== 5'b00010) begin
            failures++;
            $display("FAIL subnormal_norm exp_a=%h frac_a=%h exp_b=%h frac_b=%h cls_a=%b want 3ea/40000000/000/40000000/00010",
                     o.a.exp, o.a.frac, o.b.exp, o.b.frac, o.a.cls);
        end
`else
        send_one(32'h0040_0000, 32'h8000_0001, o, v1, v2);
        checks++;
        if (o.a.frac !== 32'h0 || o.a.exp !== 10'h0 || o.a.cls !== 5'b00011 || o.b.cls !== 5'b00011
            || o.b.sign !== 1'b1 || o.b.rexp !== 8'h00) begin
            failures++;
            $display("FAIL subnormal_flush frac_a=%h exp_a=%h cls_a=%b cls_b=%b sign_b=%b want 0/0/00011/00011/1",
                     o.a.frac, o.a.exp, o.a.cls, o.b.cls, o.b.sign);
        end
`endif
    endtask

    task automatic test_random();
        obs_t pre;
        logic held;
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            a         = rand_op();
            b         = rand_op();
            out_ready = ($urandom % 3) != 0;
            #1;
            held = out_valid && !out_ready;
            pre  = sample();
            tick();
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || sample() !== pre) begin
                    failures++;
                    $display("FAIL random_stall_stable cyc=%0d got=%h want=%h", c, sample(), pre);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== model(exp_q[i])) begin
                failures++;
                $display("FAIL random_item idx=%0d got=%h want=%h", i, got_q[i], model(exp_q[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa[4], pb[4];
        obs_t snap;
        int idx;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 4; i++) begin
            pa[i] = rand_op();
            pb[i] = rand_op();
        end
        idx = 0;
        snap = '0;
        for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
            in_valid  = idx < 4;
            a         = pa[idx % 4];
            b         = pb[idx % 4];
            out_ready = c >= 5;
            #1;
            if (c == 2) begin
                checks++;
                if (in_ready !== 1'b0 || exp_q.size() != 2) begin
                    failures++;
                    $display("FAIL bp_in_ready in_ready=%b accepted=%0d want 0/2", in_ready, exp_q.size());
                end
                snap = sample();
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (out_valid !== 1'b1 || sample() !== snap) begin
                    failures++;
                    $display("FAIL bp_stable cyc=%0d got=%h want=%h", c, sample(), snap);
                end
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (got_q.size() != 4) begin
            failures++;
            $display("FAIL bp_count got=%0d want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== model({pa[i], pb[i]})) begin
                failures++;
                $display("FAIL bp_order idx=%0d got=%h want=%h", i, got_q[i], model({pa[i], pb[i]}));
            end
        end
    endtask

    task automatic test_reset_midstream();
        obs_t o;
        logic v1, v2;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = rand_op(); b = rand_op();
            tick();
        end
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sample() !== '0) begin
            failures++;
            $display("FAIL midreset_clear out_valid=%b in_ready=%b outs=%h want 0/1/0",
                     out_valid, in_ready, sample());
        end
        repeat (2) tick();
        reset_n = 1'b1; out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_stale emitted=%0d want 0", got_q.size());
        end
        send_one(32'h4120_0000, 32'hBF00_0000, o, v1, v2);
        checks++;
        if (o !== model({32'h4120_0000, 32'hBF00_0000}) || v2 !== 1'b1) begin
            failures++;
            $display("FAIL midreset_next got=%h want=%h", o, model({32'h4120_0000, 32'hBF00_0000}));
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        exp_q.delete(); got_q.delete();
        stalls = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; a = rand_op(); b = rand_op();
            #1;
            if (in_ready !== 1'b1) stalls++;
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (stalls != 0 || got_q.size() != 16) begin
            failures++;
            $display("FAIL b2b_throughput stalls=%0d emitted=%0d want 0/16", stalls, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== model(exp_q[i])) begin
                failures++;
                $display("FAIL b2b_item idx=%0d got=%h want=%h", i, got_q[i], model(exp_q[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
